// File: rtl/des_pkg.sv
// Shared DES definitions: FSM state type, permutation tables, S-boxes and helpers.
// Bit numbering: FIPS-46 bit n lives at vector index n-1, so every table entry T gives out[i] = in[T-1].
package des_pkg;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } des_state_t;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each box is stored row-major: entry [row*16 + col].
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    function automatic logic [63:0] des_ip(input logic [63:0] d);
        logic [63:0] o;
        for (int n = 0; n < 64; n++) o[n] = d[6'(IP_TBL[n] - 1)];
        return o;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] d);
        logic [63:0] o;
        for (int n = 0; n < 64; n++) o[n] = d[6'(FP_TBL[n] - 1)];
        return o;
    endfunction

    function automatic logic [47:0] des_e(input logic [31:0] r);
        logic [47:0] o;
        for (int n = 0; n < 48; n++) o[n] = r[5'(E_TBL[n] - 1)];
        return o;
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] s);
        logic [31:0] o;
        for (int n = 0; n < 32; n++) o[n] = s[5'(P_TBL[n] - 1)];
        return o;
    endfunction

    // x[0] is the first FIPS bit of the group: row = x[0],x[5]; column = x[1..4].
    function automatic logic [3:0] des_sbox(input logic [2:0] box, input logic [5:0] x);
        return 4'(SBOX[box][{x[0], x[5], x[1], x[2], x[3], x[4]}]);
    endfunction

endpackage

// File: rtl/des_f_function.sv
// Combinational DES round function f(R, K): expansion, key mix, eight S-boxes, P permutation.
module des_f_function
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] mixed;
    logic [31:0] sbox_out;

    assign mixed = des_e(r) ^ k;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sbox
            logic [3:0] v;
            assign v = des_sbox(3'(gi), mixed[6*gi +: 6]);
            // The S-box MSB is the lowest-numbered FIPS bit of the nibble.
            assign sbox_out[4*gi +: 4] = {v[0], v[1], v[2], v[3]};
        end
    endgenerate

    assign f = des_p(sbox_out);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: IP, 16 Feistel rounds (ROUNDS_PER_CYCLE per clock: 1, 2 or 4), FP.
// Define DES_DECRYPT_EN to honour the decrypt input; otherwise the engine is encrypt-only.
module des_round_engine
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       data_in,
    input  logic              decrypt,
    input  logic [0:15][47:0] round_keys,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       data_out,
    output logic              busy
);

    localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST_CNT = 5'(DES_ROUNDS - ROUNDS_PER_CYCLE);

    des_state_t  state_reg, state_next;
    logic [4:0]  rnd_cnt_reg, rnd_cnt_next;
    logic [31:0] l_reg, l_next;
    logic [31:0] r_reg, r_next;
    logic [63:0] data_out_reg, data_out_next;
    logic        out_valid_reg, out_valid_next;
    logic [63:0] ip_blk;
    logic [31:0] l_fin, r_fin;

`ifdef DES_DECRYPT_EN
    logic        mode_reg, mode_next;
`else
    logic        decrypt_unused;
    assign decrypt_unused = decrypt;
`endif

    assign ip_blk = des_ip(data_in);

    genvar gi;
    generate
        for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
            logic [31:0] l_in, r_in, l_out, r_out, f_out;
            logic [3:0]  rnd_abs, key_idx;

            if (gi == 0) begin : g_first
                assign l_in = l_reg;
                assign r_in = r_reg;
            end else begin : g_chain
                assign l_in = g_round[gi-1].l_out;
                assign r_in = g_round[gi-1].r_out;
            end

            assign rnd_abs = rnd_cnt_reg[3:0] + 4'(gi);
`ifdef DES_DECRYPT_EN
            assign key_idx = mode_reg ? (4'd15 - rnd_abs) : rnd_abs;
`else
            assign key_idx = rnd_abs;
`endif

            des_f_function u_f (
                .r (r_in),
                .k (round_keys[key_idx]),
                .f (f_out)
            );

            assign l_out = r_in;
            assign r_out = l_in ^ f_out;
        end
    endgenerate

    assign l_fin = g_round[ROUNDS_PER_CYCLE-1].l_out;
    assign r_fin = g_round[ROUNDS_PER_CYCLE-1].r_out;

    always_comb begin
        state_next     = state_reg;
        rnd_cnt_next   = rnd_cnt_reg;
        l_next         = l_reg;
        r_next         = r_reg;
        data_out_next  = data_out_reg;
        out_valid_next = out_valid_reg;
`ifdef DES_DECRYPT_EN
        mode_next      = mode_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    l_next       = ip_blk[31:0];
                    r_next       = ip_blk[63:32];
                    rnd_cnt_next = 5'd0;
`ifdef DES_DECRYPT_EN
                    mode_next    = decrypt;
`endif
                    state_next   = RUN;
                end
            end
            RUN: begin
                l_next       = l_fin;
                r_next       = r_fin;
                rnd_cnt_next = rnd_cnt_reg + CNT_STEP;
                if (rnd_cnt_reg == LAST_CNT) begin
                    // Final swap: the preoutput block is R16 followed by L16.
                    data_out_next  = des_fp({l_fin, r_fin});
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rnd_cnt_reg   <= 5'd0;
            l_reg         <= 32'd0;
            r_reg         <= 32'd0;
            data_out_reg  <= 64'd0;
            out_valid_reg <= 1'b0;
`ifdef DES_DECRYPT_EN
            mode_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            rnd_cnt_reg   <= rnd_cnt_next;
            l_reg         <= l_next;
            r_reg         <= r_next;
            data_out_reg  <= data_out_next;
            out_valid_reg <= out_valid_next;
`ifdef DES_DECRYPT_EN
            mode_reg      <= mode_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign data_out  = data_out_reg;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine with a scoreboard of expected blocks (FIPS hex values bit-reversed).
module tb_des_round_engine;

    typedef logic [0:15][47:0] rk_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        in_valid2, in_ready2, in_valid4, in_ready4;
    logic [63:0] data_in;
    logic        decrypt;
    rk_t         round_keys;
    logic        out_valid, out_ready, busy;
    logic        out_valid2, out_valid4, busy2, busy4;
    logic [63:0] data_out, data_out2, data_out4;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_edge = 0;
    int          rise_edge = 0;
    logic        prev_ov = 1'b0;
    logic [63:0] cur_exp;
    logic [63:0] exp_q [$];
    int          acc_edges [$];

    always #5 clk = ~clk;

    des_round_engine #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .decrypt(decrypt), .round_keys(round_keys), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );
    des_round_engine #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .data_in(data_in),
        .decrypt(decrypt), .round_keys(round_keys), .out_valid(out_valid2), .out_ready(1'b1),
        .data_out(data_out2), .busy(busy2)
    );
    des_round_engine #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .data_in(data_in),
        .decrypt(decrypt), .round_keys(round_keys), .out_valid(out_valid4), .out_ready(1'b1),
        .data_out(data_out4), .busy(busy4)
    );

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[i] = x[63-i];
        return o;
    endfunction

    // Key schedule in vector-index form (index n-1 holds FIPS bit n).
    function automatic rk_t key_sched(input logic [63:0] key_hex);
        logic [63:0] k;
        logic [27:0] c, d;
        logic [55:0] cd;
        rk_t         rk;
        k = rev64(key_hex);
        for (int i = 0; i < 28; i++) begin
            c[i] = k[PC1[i] - 1];
            d[i] = k[PC1[i+28] - 1];
        end
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[0], c[27:1]};
                d = {d[0], d[27:1]};
            end
            cd = {d, c};
            for (int n = 0; n < 48; n++) rk[r][n] = cd[PC2[n] - 1];
        end
        return rk;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        acc, ohs;
        logic [63:0] dout;
        acc  = in_valid && in_ready;
        ohs  = out_valid && out_ready;
        dout = data_out;
        @(posedge clk);
        #1;
        cyc++;
        if (acc && !rst) begin
            exp_q.push_back(cur_exp);
            acc_edge = cyc;
            acc_edges.push_back(cyc);
        end
        if (ohs && !rst) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_output observed=%h expected=none", dout);
            end
            if (exp_q.size() > 0) chk("data_out", dout, exp_q.pop_front());
        end
        if (out_valid && !prev_ov) rise_edge = cyc;
        prev_ov = out_valid;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) tick();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_block(input string tag, input logic [63:0] pt_hex, input logic dec,
                             input logic [63:0] exp_hex);
        data_in   = rev64(pt_hex);
        decrypt   = dec;
        cur_exp   = rev64(exp_hex);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        drain({tag, "_drain"});
        chk({tag, "_latency"}, 64'(rise_edge - acc_edge), 64'd16);
    endtask

    task automatic run_fast(input string tag, input logic [63:0] pt_hex, input logic [63:0] exp_hex);
        int          lat2, lat4;
        logic [63:0] d2, d4;
        lat2 = -1;
        lat4 = -1;
        d2   = '0;
        d4   = '0;
        data_in   = rev64(pt_hex);
        decrypt   = 1'b0;
        in_valid2 = 1'b1;
        in_valid4 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        in_valid4 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (out_valid2 && lat2 < 0) begin lat2 = k; d2 = data_out2; end
            if (out_valid4 && lat4 < 0) begin lat4 = k; d4 = data_out4; end
        end
        chk({tag, "_rpc2_data"}, d2, rev64(exp_hex));
        chk({tag, "_rpc2_latency"}, 64'(lat2), 64'd8);
        chk({tag, "_rpc4_data"}, d4, rev64(exp_hex));
        chk({tag, "_rpc4_latency"}, 64'(lat4), 64'd4);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] keys [3];
        logic [63:0] pts [3];
        logic [63:0] exps [3];
        int          seen_ov;

        rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0;
        out_ready = 1'b0; decrypt = 1'b0; data_in = '0; cur_exp = '0;
        round_keys = key_sched(64'h133457799BBCDFF1);
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_data_out", data_out, 64'd0);
        rst = 1'b0;
        tick();

        // Encrypt the classic FIPS example.
        run_block("enc1", 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);

`ifdef DES_DECRYPT_EN
        run_block("dec1", 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF);
`else
        run_block("dec_ignored", 64'h0123456789ABCDEF, 1'b1, 64'h85E813540F0AB405);
`endif

        round_keys = key_sched(64'h0E329232EA6D0D73);
        run_block("enc2", 64'h8787878787878787, 1'b0, 64'h0000000000000000);
        run_fast("fast_a", 64'h8787878787878787, 64'h0000000000000000);
        round_keys = key_sched(64'h133457799BBCDFF1);
        run_fast("fast_b", 64'h0123456789ABCDEF, 64'h85E813540F0AB405);

        // Backpressure in DONE with a new block already offered.
        out_ready = 1'b0;
        data_in   = rev64(64'h0123456789ABCDEF);
        decrypt   = 1'b0;
        cur_exp   = rev64(64'h85E813540F0AB405);
        in_valid  = 1'b1;
        tick();
        for (int n = 0; n < 40 && !out_valid; n++) tick();
        chk("bp_out_valid_rise", out_valid, 1);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_data_hold", data_out, rev64(64'h85E813540F0AB405));
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        chk("bp_no_accept", 64'(exp_q.size()), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("bp_accept_edge", 64'(acc_edge), 64'(cyc));
        drain("bp_drain");

        // Reset during RUN once round 7 is reached.
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 7; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        seen_ov = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (out_valid) seen_ov++;
        end
        chk("abort_no_output", 64'(seen_ov), 64'd0);

        // Three back-to-back blocks with in_valid and out_ready held high.
        keys[0] = 64'h133457799BBCDFF1; pts[0] = 64'h0123456789ABCDEF; exps[0] = 64'h85E813540F0AB405;
        keys[1] = 64'h0E329232EA6D0D73; pts[1] = 64'h8787878787878787; exps[1] = 64'h0000000000000000;
        keys[2] = 64'h0000000000000000; pts[2] = 64'h0000000000000000; exps[2] = 64'h8CA64DE9C1B123A7;
        acc_edges.delete();
        round_keys = key_sched(keys[0]);
        data_in    = rev64(pts[0]);
        cur_exp    = rev64(exps[0]);
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int n = 0; n < 40 && acc_edges.size() < b + 1; n++) tick();
            if (b == 2) in_valid = 1'b0;
            for (int n = 0; n < 40 && !out_valid; n++) tick();
            if (b < 2) begin
                round_keys = key_sched(keys[b+1]);
                data_in    = rev64(pts[b+1]);
                cur_exp    = rev64(exps[b+1]);
            end
        end
        drain("b2b_drain");
        chk("b2b_accepts", 64'(acc_edges.size()), 64'd3);
        if (acc_edges.size() == 3) begin
            chk("b2b_spacing_01", 64'(acc_edges[1] - acc_edges[0]), 64'd18);
            chk("b2b_spacing_12", 64'(acc_edges[2] - acc_edges[1]), 64'd18);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
